// File: rtl/multi_app_traffic_pkg.sv
// Shared definitions for the multi-channel application traffic block:
// header field positions, FSM encodings and control/status bit indices.
package multi_app_traffic_pkg;

  // Header word layout
  localparam int HDR_ID_LSB  = 0;
  localparam int HDR_ID_MSB  = 7;
  localparam int HDR_LEN_LSB = 8;
  localparam int HDR_LEN_MSB = 23;

  // app_mode bit indices
  localparam int MODE_IN_EN  = 0;
  localparam int MODE_OUT_EN = 1;

  // app_status bit indices
  localparam int ST_ERR_BAD_CH   = 0;
  localparam int ST_ERR_ZERO_LEN = 1;
  localparam int ST_IN_BUSY      = 2;
  localparam int ST_OUT_PKT      = 3;
  localparam int ST_GRANT_LSB    = 4;
  localparam int ST_GRANT_MSB    = 6;

  typedef enum logic [1:0] {
    IN_HDR     = 2'd0,
    IN_DATA    = 2'd1,
    IN_DISCARD = 2'd2
  } in_state_e;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_ARB  = 2'd1,
    OUT_PKT  = 2'd2
  } out_state_e;

  // Width of a channel index; at least one bit so N_CH=1 still has a signal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_app_traffic_rr_arbiter.sv
// Round-robin channel picker: returns the first requesting channel after
// ptr, wrapping modulo N_CH, so the last served channel has lowest priority.
module rr_arbiter
  import multi_app_traffic_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int IW   = idx_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   grant,
  output logic            any
);

  logic [IW-1:0] idx;

  // Scan from the farthest candidate back to ptr+1 so the nearest wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = N_CH; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % N_CH);
      if (req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_app_traffic.sv
// Demultiplexes headed packets from one input FIFO to N_CH application
// channels and multiplexes whole result packets from those channels back
// into one output FIFO with round-robin fairness.
module multi_app_traffic
  import multi_app_traffic_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [W-1:0]      din,
  input  logic              empty,
  output logic              rd_en,
  output logic [W-1:0]      ch_dout,
  output logic [N_CH-1:0]   ch_wr_en,
  input  logic [N_CH-1:0]   ch_full,
  input  logic [N_CH*W-1:0] ch_din,
  input  logic [N_CH-1:0]   ch_empty,
  input  logic [N_CH-1:0]   ch_last,
  output logic [N_CH-1:0]   ch_rd_en,
  output logic [W-1:0]      dout,
  output logic              wr_en,
  input  logic              full,
  output logic              pkt_end,
  input  logic [7:0]        app_mode,
  output logic [7:0]        app_status
);

  localparam int            IW      = idx_w(N_CH);
  localparam logic [7:0]    N_CH_ID = 8'(N_CH);

  in_state_e       in_state_q, in_state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic            err_bad_q, err_bad_d;
  logic            err_zero_q, err_zero_d;
  out_state_e      out_state_q, out_state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   g_q, g_d;

  logic            rd_en_c, wr_en_c, pkt_end_c;
  logic [N_CH-1:0] ch_wr_en_c, ch_rd_en_c;
  logic [IW-1:0]   arb_grant;
  logic            arb_any;
  logic [7:0]      hdr_id;
  logic [15:0]     hdr_len;
  logic [W-1:0]    ch_words [N_CH];
  logic            unused_mode;

  assign hdr_id      = din[HDR_ID_MSB:HDR_ID_LSB];
  assign hdr_len     = din[HDR_LEN_MSB:HDR_LEN_LSB];
  assign unused_mode = ^app_mode[7:2];

  for (genvar k = 0; k < N_CH; k++) begin : g_unpack
    assign ch_words[k] = ch_din[k*W +: W];
  end

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req   (~ch_empty),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .any   (arb_any)
  );

  // Input side: decode headers, steer payload to the selected channel, drop bad ones.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    in_state_d = in_state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    err_bad_d  = err_bad_q;
    err_zero_d = err_zero_q;
    rd_en_c    = 1'b0;
    ch_wr_en_c = '0;
    unique case (in_state_q)
      IN_HDR: begin
        if (!empty && app_mode[MODE_IN_EN]) begin
          rd_en_c = 1'b1;
          if (hdr_len == 16'd0) begin
            err_zero_d = 1'b1;
          end else if (hdr_id < N_CH_ID) begin
            in_state_d = IN_DATA;
            sel_d      = IW'(hdr_id);
            cnt_d      = hdr_len;
          end else begin
            in_state_d = IN_DISCARD;
            cnt_d      = hdr_len;
            err_bad_d  = 1'b1;
          end
        end
      end
      IN_DATA: begin
        rd_en_c           = !empty && !ch_full[sel_q];
        ch_wr_en_c[sel_q] = rd_en_c;
      end
      IN_DISCARD: rd_en_c = !empty;
      default:    in_state_d = IN_HDR;
    endcase
    // Payload transfers count down; the one with cnt=1 closes the packet.
    if (in_state_q != IN_HDR && rd_en_c) begin
      cnt_d = cnt_q - 16'd1;
      if (cnt_q == 16'd1) in_state_d = IN_HDR;
    end
  end

  // Output side: arbitrate between channels, then drain one whole packet.
  always_comb begin
    out_state_d = out_state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    wr_en_c     = 1'b0;
    pkt_end_c   = 1'b0;
    ch_rd_en_c  = '0;
    unique case (out_state_q)
      OUT_IDLE: if (app_mode[MODE_OUT_EN]) out_state_d = OUT_ARB;
      OUT_ARB: begin
        if (arb_any) begin
          g_d         = arb_grant;
          out_state_d = OUT_PKT;
        end
      end
      OUT_PKT: begin
        wr_en_c         = !ch_empty[g_q] && !full;
        ch_rd_en_c[g_q] = wr_en_c;
        pkt_end_c       = wr_en_c && ch_last[g_q];
        if (pkt_end_c) begin
          ptr_d       = g_q;
          out_state_d = OUT_IDLE;
        end
      end
      default: out_state_d = OUT_IDLE;
    endcase
  end

  // State registers for both FSMs, with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (RESET) begin
      in_state_q  <= IN_HDR;
      cnt_q       <= '0;
      sel_q       <= '0;
      err_bad_q   <= 1'b0;
      err_zero_q  <= 1'b0;
      out_state_q <= OUT_IDLE;
      ptr_q       <= IW'(N_CH - 1);
      g_q         <= '0;
    end else begin
      in_state_q  <= in_state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      err_bad_q   <= err_bad_d;
      err_zero_q  <= err_zero_d;
      out_state_q <= out_state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
    end
  end

  // Strobes are qualified with RESET so nothing moves during the reset cycle itself.
  assign rd_en    = rd_en_c & ~RESET;
  assign ch_wr_en = ch_wr_en_c & {N_CH{~RESET}};
  assign ch_rd_en = ch_rd_en_c & {N_CH{~RESET}};
  assign wr_en    = wr_en_c & ~RESET;
  assign pkt_end  = pkt_end_c & ~RESET;
  assign ch_dout  = din;
  assign dout     = ch_words[g_q];

  assign app_status = {1'b0, 3'(g_q), out_state_q == OUT_PKT, in_state_q != IN_HDR,
                       err_zero_q, err_bad_q};

endmodule
